stage_memory0_arb: RTL and testbench
====================================

Name: stage_memory0_arb

Overview:
- Parametrised successor of the memory-0 pipeline stage.
- Registers execute-stage results and forwards the address to decode.
- Arbitrates a single dcache read port between NREQ refill/walk requesters and the pipeline's own load/store lookup.
- Adds fixed-priority or round-robin requester arbitration, a starvation guard for the pipeline op, and a stall when the op loses arbitration.

Parameters:
NREQ, 2, number of physical-address requesters (fetch1, memory1, PTW, ...); index 0 is highest priority in fixed mode
RR_MODE, 0, 0 = fixed priority among requesters; 1 = round-robin
PA_W, 29, physical address width; requester addresses are [PA_W-1:2]
STARVE_MAX, 4, consecutive lost cycles after which the pipeline op is forced to win (range 1..15)

Ports:
clk_core  in  1  core clock
reset  in  1  synchronous, active-high reset
ex_valid / ex_stall / ex_exc  in  1 each  execute handshake and exception flag
ex_exc_cause  in  ecause_t  exception cause
ex_pc  in  [31:2]  instruction PC
ex_data0 / ex_data1  in  32 each  effective address / store data
ex_mem_read / ex_mem_write / ex_mem_extend  in  1 each  access type and sign-extend flag
ex_mem_width  in  2  access width
ex_wb_reg  in  5  destination register
mem0_stall  out  1  back-pressure to execute
csr_kill  in  1  pipeline flush
csr_satp  in  32  satp; ASID = [30:22]
rq_read  in  NREQ  per-requester read request
rq_addr  in  NREQ*(PA_W-2)  packed word addresses; requester i occupies slice i
rq_grant  out  NREQ  one-hot combinational grant
mem0_dc_read / mem0_dc_trans  out  1 each  dcache read strobe / translate request
mem0_dc_asid  out  9  ASID to dcache
mem0_dc_addr  out  [31:2]  dcache address
mem1_stall  in  1  memory1 back-pressure
mem0_valid / mem0_exc  out  1 each  stage valid and exception flag
mem0_exc_cause  out  ecause_t  registered exception cause
mem0_pc  out  [31:2]  registered PC
mem0_read / mem0_write / mem0_extend  out  1 each  registered access type
mem0_width  out  2  registered access width
mem0_addr / mem0_wdata  out  32 each  registered address / store data
mem0_wb_reg  out  5  registered destination register
mem0_fwd_data  out  32  equals mem0_addr
mem0_starved  out  1  high while the starvation counter is at STARVE_MAX

Behaviour:
Reset:
- All registered outputs clear to 0.
- rr_ptr and starve_cnt clear to 0.
- Combinational outputs follow from these values.

Capture, on a cycle where ~mem0_stall | csr_kill:
- mem0_valid <= ex_valid & ~ex_stall & ~ex_exc & ~csr_kill
- mem0_exc <= ex_exc & ~csr_kill
- Payload <= ex_* fields; mem0_addr <= ex_data0; mem0_wdata <= ex_data1.
- Otherwise all registers hold.

Arbitration (combinational):
- any_rq = |rq_read.
- op_force = mem0_valid & (starve_cnt == STARVE_MAX).
- If any_rq & ~op_force, exactly one requester is granted:
  - RR_MODE=0: the lowest set index.
  - RR_MODE=1: the first set index at or after rr_ptr, wrapping modulo NREQ.
  - Outputs: mem0_dc_read=1, mem0_dc_trans=0, mem0_dc_addr = zero-extended rq_addr[g].
- Else if mem0_valid & ~mem1_stall:
  - mem0_dc_read=1, mem0_dc_trans=1, mem0_dc_addr = mem0_addr[31:2]; rq_grant=0.
- Else: mem0_dc_read=0, mem0_dc_addr=0, rq_grant=0.
- mem0_dc_asid always equals satp[30:22].

Stall:
- mem0_stall = ((mem0_valid | mem0_exc) & mem1_stall) | (mem0_valid & |rq_grant).

Round-robin pointer:
- When RR_MODE=1 and a grant occurs, rr_ptr <= (g+1) mod NREQ.
- Non-power-of-two NREQ wraps correctly.
- rr_ptr is unused in fixed mode.

Starvation counter:
- Increments, saturating at STARVE_MAX, when mem0_valid & ~mem1_stall & |rq_grant.
- Clears when the pipeline op issues, when mem0_valid=0, or on csr_kill.
- Holds while mem1_stall (no penalty is charged).

Boundary conditions:
- csr_kill in the same cycle as a grant: the grant still proceeds; refills are not flushed.
- Exception-only entries (mem0_exc=1, mem0_valid=0) never issue a dcache read.
- Requests are not latched: a requester must hold rq_read until granted.
- Reset asserted mid-arbitration takes effect at the next edge; rq_grant is 0 during reset.

Decomposition:
- Package mem0_pkg: PA_W default, STARVE_MAX default, and a function to unpack rq_addr slices.
- ecause_t stays in defines.svh.
- Sub-module mem0_rr_arb (params NREQ, RR_MODE): request vector plus pointer in, one-hot grant plus index out, owns rr_ptr.

Test Plan:
1. Reset then idle: mem0_valid=0, mem0_dc_read=0, rq_grant=0, mem0_starved=0.
2. Load, ex_data0=0x80001234, no requesters: next cycle mem0_dc_read=1, dc_trans=1, dc_addr=0x80001234>>2, mem0_stall=0.
3. NREQ=3, RR_MODE=1, rq_read=3'b111 held for 6 cycles: grants 001, 010, 100, 001, ...
4. Pipeline op valid, rq_read[0] held, STARVE_MAX=4: op stalls 4 cycles, issues on cycle 5 (dc_trans=1), mem0_starved=1 that cycle, then the counter clears.
5. mem1_stall=1 with a valid op: mem0_stall=1, dc_read=0 from the op, payload held; csr_kill pulse clears mem0_valid next cycle.
6. RR_MODE=0, rq_read=2'b11: rq_grant=01 every cycle, and dc_addr matches slice 0 zero-extended.

Source files
------------

// File: rtl/mem0_pkg.sv
// mem0_pkg: shared types and helpers for the memory-0 arbitration stage.
//   ecause_t     : exception cause code carried down the pipeline
//   mem0_pay_t   : registered execute payload held by memory-0
//   rq_slice()   : extracts requester i's word address from the packed
//                  rq_addr bus, zero-extended to a [31:2] dcache address
package mem0_pkg;

    localparam int PA_W_DEF       = 29;
    localparam int STARVE_MAX_DEF = 4;
    // Widest packed requester-address bus rq_slice() accepts (16 x 30 bits).
    localparam int RQ_MAXW        = 16 * 30;

    typedef logic [4:0] ecause_t;

    typedef struct packed {
        ecause_t     exc_cause;
        logic [31:2] pc;
        logic        read;
        logic        write;
        logic        extend;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  wb_reg;
    } mem0_pay_t;

    function automatic logic [31:2] rq_slice(input logic [RQ_MAXW-1:0] vec,
                                             input int idx, input int w);
        logic [31:2] r;
        r = '0;
        for (int b = 0; b < 30; b++)
            if (b < w && (idx * w + b) < RQ_MAXW) r[b+2] = vec[idx*w+b];
        return r;
    endfunction

endpackage

// File: rtl/stage_memory0_arb_if.sv
// stage_memory0_arb_if: requester and dcache read-port bundle.
//   rq_read/rq_addr : per-requester read request and packed word address
//   rq_grant        : one-hot grant back to the requesters
//   mem0_dc_*       : dcache read strobe, translate flag, ASID, address
// master = the arbiter stage, slave = requesters/dcache side.
interface stage_memory0_arb_if #(
    parameter int NREQ = 2,
    parameter int PA_W = 29
);
    logic [NREQ-1:0]          rq_read;
    logic [NREQ*(PA_W-2)-1:0] rq_addr;
    logic [NREQ-1:0]          rq_grant;
    logic                     mem0_dc_read;
    logic                     mem0_dc_trans;
    logic [8:0]               mem0_dc_asid;
    logic [31:2]              mem0_dc_addr;

    modport master (
        input  rq_read, rq_addr,
        output rq_grant, mem0_dc_read, mem0_dc_trans, mem0_dc_asid, mem0_dc_addr
    );
    modport slave (
        output rq_read, rq_addr,
        input  rq_grant, mem0_dc_read, mem0_dc_trans, mem0_dc_asid, mem0_dc_addr
    );
endinterface

// File: rtl/mem0_rr_arb.sv
// mem0_rr_arb: requester arbiter, fixed priority or round-robin.
//   clk, reset : core clock, synchronous active-high reset
//   req_i      : request vector (already masked by the caller)
//   grant_o    : one-hot grant, idx_o : granted index
// Owns the round-robin pointer; in fixed mode the pointer never moves.
module mem0_rr_arb #(
    parameter int NREQ    = 2,
    parameter int RR_MODE = 0,
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int            j;

    // Scan NREQ positions starting at the pointer (or 0 in fixed mode);
    // the modulo keeps non-power-of-two NREQ wrapping correctly.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (RR_MODE != 0) ? (int'(ptr_q) + k) % NREQ : k;
            if (!found && req_i[IW'(j)]) begin
                found            = 1'b1;
                grant_o[IW'(j)]  = 1'b1;
                idx_o            = IW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (RR_MODE != 0 && found)
            ptr_d = (int'(idx_o) + 1 >= NREQ) ? '0 : IW'(int'(idx_o) + 1);
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/stage_memory0_arb.sv
// stage_memory0_arb: memory-0 pipeline stage with dcache port arbitration.
//   clk_core, reset : core clock, synchronous active-high reset
//   ex_*            : execute-stage results captured into memory-0
//   mem0_stall      : back-pressure to execute
//   csr_kill        : pipeline flush; csr_satp supplies the ASID
//   dc              : requester bus and dcache read port
//   mem1_stall      : memory-1 back-pressure
//   mem0_*          : registered stage outputs, forwarding, starvation flag
// Requesters win the dcache port over the pipeline op until the op has lost
// STARVE_MAX consecutive cycles, then the op is forced through.
module stage_memory0_arb
    import mem0_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int RR_MODE    = 0,
    parameter int PA_W       = PA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk_core,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_exc,
    input  ecause_t     ex_exc_cause,
    input  logic [31:2] ex_pc,
    input  logic [31:0] ex_data0,
    input  logic [31:0] ex_data1,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_extend,
    input  logic [1:0]  ex_mem_width,
    input  logic [4:0]  ex_wb_reg,
    output logic        mem0_stall,
    input  logic        csr_kill,
    input  logic [31:0] csr_satp,
    stage_memory0_arb_if.master dc,
    input  logic        mem1_stall,
    output logic        mem0_valid,
    output logic        mem0_exc,
    output ecause_t     mem0_exc_cause,
    output logic [31:2] mem0_pc,
    output logic        mem0_read,
    output logic        mem0_write,
    output logic        mem0_extend,
    output logic [1:0]  mem0_width,
    output logic [31:0] mem0_addr,
    output logic [31:0] mem0_wdata,
    output logic [4:0]  mem0_wb_reg,
    output logic [31:0] mem0_fwd_data,
    output logic        mem0_starved
);
    localparam int AW = PA_W - 2;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic        valid_q, valid_d, exc_q, exc_d;
    mem0_pay_t   pay_q, pay_d;
    logic [3:0]  starve_q, starve_d;
    logic        op_force, cap;
    logic [NREQ-1:0] req_m, gnt;
    logic [IW-1:0]   gidx;
    logic        unused_satp;

    assign unused_satp = ^{csr_satp[31], csr_satp[21:0]};

    assign op_force = valid_q & (starve_q == 4'(STARVE_MAX));
    // A forced op or reset suppresses every grant.
    assign req_m    = (op_force | reset) ? '0 : dc.rq_read;

    mem0_rr_arb #(.NREQ(NREQ), .RR_MODE(RR_MODE)) u_arb (
        .clk     (clk_core),
        .reset   (reset),
        .req_i   (req_m),
        .grant_o (gnt),
        .idx_o   (gidx)
    );

    assign dc.rq_grant     = gnt;
    assign dc.mem0_dc_asid = csr_satp[30:22];

    always_comb begin
        dc.mem0_dc_read  = 1'b0;
        dc.mem0_dc_trans = 1'b0;
        dc.mem0_dc_addr  = '0;
        if (|gnt) begin
            dc.mem0_dc_read = 1'b1;
            dc.mem0_dc_addr = rq_slice(RQ_MAXW'(dc.rq_addr), int'(gidx), AW);
        end else if (valid_q & ~mem1_stall) begin
            dc.mem0_dc_read  = 1'b1;
            dc.mem0_dc_trans = 1'b1;
            dc.mem0_dc_addr  = pay_q.addr[31:2];
        end
    end

    assign mem0_stall = ((valid_q | exc_q) & mem1_stall) | (valid_q & (|gnt));
    assign cap        = ~mem0_stall | csr_kill;

    always_comb begin
        valid_d = valid_q;
        exc_d   = exc_q;
        pay_d   = pay_q;
        if (cap) begin
            valid_d = ex_valid & ~ex_stall & ~ex_exc & ~csr_kill;
            exc_d   = ex_exc & ~csr_kill;
            pay_d   = '{exc_cause: ex_exc_cause, pc: ex_pc, read: ex_mem_read,
                        write: ex_mem_write, extend: ex_mem_extend,
                        width: ex_mem_width, addr: ex_data0, wdata: ex_data1,
                        wb_reg: ex_wb_reg};
        end
    end

    // Losses only count when memory-1 could have accepted the op.
    always_comb begin
        starve_d = '0;
        if (csr_kill | ~valid_q)
            starve_d = '0;
        else if (mem1_stall)
            starve_d = starve_q;
        else if (|gnt)
            starve_d = (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            valid_q  <= 1'b0;
            exc_q    <= 1'b0;
            pay_q    <= '0;
            starve_q <= '0;
        end else begin
            valid_q  <= valid_d;
            exc_q    <= exc_d;
            pay_q    <= pay_d;
            starve_q <= starve_d;
        end
    end

    assign mem0_valid     = valid_q;
    assign mem0_exc       = exc_q;
    assign mem0_exc_cause = pay_q.exc_cause;
    assign mem0_pc        = pay_q.pc;
    assign mem0_read      = pay_q.read;
    assign mem0_write     = pay_q.write;
    assign mem0_extend    = pay_q.extend;
    assign mem0_width     = pay_q.width;
    assign mem0_addr      = pay_q.addr;
    assign mem0_wdata     = pay_q.wdata;
    assign mem0_wb_reg    = pay_q.wb_reg;
    assign mem0_fwd_data  = pay_q.addr;
    assign mem0_starved   = (starve_q == 4'(STARVE_MAX));
endmodule

// File: tb/tb_stage_memory0_arb.sv
// Bench for stage_memory0_arb: two instances share the execute side,
// d=0 is NREQ=3 round-robin, d=1 is NREQ=2 fixed priority.
module tb_stage_memory0_arb;
    import mem0_pkg::*;

    localparam int AW = 27;
    localparam int SM = 4;

    logic clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    logic        reset, ex_valid, ex_stall, ex_exc, ex_mem_read, ex_mem_write;
    logic        ex_mem_extend, csr_kill, mem1_stall;
    ecause_t     ex_exc_cause;
    logic [31:2] ex_pc;
    logic [31:0] ex_data0, ex_data1, csr_satp;
    logic [1:0]  ex_mem_width;
    logic [4:0]  ex_wb_reg;
    logic [2:0]  rq [2];
    logic [AW-1:0] ra [2][3];

    logic        o_stall[2], o_valid[2], o_exc[2], o_read[2], o_write[2], o_ext[2], o_starved[2];
    ecause_t     o_cause[2];
    logic [31:2] o_pc[2];
    logic [1:0]  o_width[2];
    logic [31:0] o_addr[2], o_wdata[2], o_fwd[2];
    logic [4:0]  o_wb[2];

    stage_memory0_arb_if #(.NREQ(3), .PA_W(29)) if_rr ();
    stage_memory0_arb_if #(.NREQ(2), .PA_W(29)) if_fx ();

    assign if_rr.rq_read = rq[0];
    assign if_fx.rq_read = rq[1][1:0];
    assign if_rr.rq_addr = {ra[0][2], ra[0][1], ra[0][0]};
    assign if_fx.rq_addr = {ra[1][1], ra[1][0]};

    stage_memory0_arb #(.NREQ(3), .RR_MODE(1), .PA_W(29), .STARVE_MAX(SM)) dut_rr (
        .clk_core(clk_core), .reset(reset), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_exc(ex_exc), .ex_exc_cause(ex_exc_cause), .ex_pc(ex_pc), .ex_data0(ex_data0),
        .ex_data1(ex_data1), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_extend(ex_mem_extend), .ex_mem_width(ex_mem_width), .ex_wb_reg(ex_wb_reg),
        .mem0_stall(o_stall[0]), .csr_kill(csr_kill), .csr_satp(csr_satp), .dc(if_rr),
        .mem1_stall(mem1_stall), .mem0_valid(o_valid[0]), .mem0_exc(o_exc[0]),
        .mem0_exc_cause(o_cause[0]), .mem0_pc(o_pc[0]), .mem0_read(o_read[0]),
        .mem0_write(o_write[0]), .mem0_extend(o_ext[0]), .mem0_width(o_width[0]),
        .mem0_addr(o_addr[0]), .mem0_wdata(o_wdata[0]), .mem0_wb_reg(o_wb[0]),
        .mem0_fwd_data(o_fwd[0]), .mem0_starved(o_starved[0]));

    stage_memory0_arb #(.NREQ(2), .RR_MODE(0), .PA_W(29), .STARVE_MAX(SM)) dut_fx (
        .clk_core(clk_core), .reset(reset), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_exc(ex_exc), .ex_exc_cause(ex_exc_cause), .ex_pc(ex_pc), .ex_data0(ex_data0),
        .ex_data1(ex_data1), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_extend(ex_mem_extend), .ex_mem_width(ex_mem_width), .ex_wb_reg(ex_wb_reg),
        .mem0_stall(o_stall[1]), .csr_kill(csr_kill), .csr_satp(csr_satp), .dc(if_fx),
        .mem1_stall(mem1_stall), .mem0_valid(o_valid[1]), .mem0_exc(o_exc[1]),
        .mem0_exc_cause(o_cause[1]), .mem0_pc(o_pc[1]), .mem0_read(o_read[1]),
        .mem0_write(o_write[1]), .mem0_extend(o_ext[1]), .mem0_width(o_width[1]),
        .mem0_addr(o_addr[1]), .mem0_wdata(o_wdata[1]), .mem0_wb_reg(o_wb[1]),
        .mem0_fwd_data(o_fwd[1]), .mem0_starved(o_starved[1]));

    int errors = 0;
    int checks = 0;

    // Reference model state per instance.
    logic      m_valid[2], m_exc[2];
    mem0_pay_t m_pay[2];
    int        m_ptr[2], m_st[2], e_gi[2];
    logic      e_stl[2];

    function automatic int nr(input int d);  return (d == 0) ? 3 : 2; endfunction
    function automatic bit rrm(input int d); return (d == 0);         endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected arbitration outcome this cycle from the model state.
    function automatic void mcomb(input int d, output int gi, output logic [2:0] g,
                                  output logic rd, output logic tr,
                                  output logic [31:2] a, output logic stl);
        int j;
        gi = -1; g = '0; rd = 1'b0; tr = 1'b0; a = '0;
        if (!reset && rq[d] != 3'b0 && !(m_valid[d] && m_st[d] == SM)) begin
            for (int k = 0; k < nr(d); k++) begin
                j = rrm(d) ? (m_ptr[d] + k) % nr(d) : k;
                if (gi < 0 && rq[d][j]) gi = j;
            end
        end
        if (gi >= 0) begin
            g[gi] = 1'b1; rd = 1'b1; a = {3'b000, ra[d][gi]};
        end else if (m_valid[d] && !mem1_stall) begin
            rd = 1'b1; tr = 1'b1; a = m_pay[d].addr[31:2];
        end
        stl = ((m_valid[d] || m_exc[d]) && mem1_stall) || (m_valid[d] && gi >= 0);
    endfunction

    // Check both instances against the model, clock once, advance the model.
    task automatic step();
        int gi;
        logic [2:0] g, og;
        logic rd, tr, stl, ord, otr;
        logic [31:2] a, oa;
        logic [8:0] oas;
        #1;
        for (int d = 0; d < 2; d++) begin
            mcomb(d, gi, g, rd, tr, a, stl);
            if (d == 0) begin
                og = if_rr.rq_grant; ord = if_rr.mem0_dc_read; otr = if_rr.mem0_dc_trans;
                oa = if_rr.mem0_dc_addr; oas = if_rr.mem0_dc_asid;
            end else begin
                og = {1'b0, if_fx.rq_grant}; ord = if_fx.mem0_dc_read; otr = if_fx.mem0_dc_trans;
                oa = if_fx.mem0_dc_addr; oas = if_fx.mem0_dc_asid;
            end
            chk($sformatf("grant%0d", d), og, g);
            chk($sformatf("dc_read%0d", d), ord, rd);
            if (rd) chk($sformatf("dc_trans%0d", d), otr, tr);
            chk($sformatf("dc_addr%0d", d), oa, a);
            chk($sformatf("asid%0d", d), oas, csr_satp[30:22]);
            chk($sformatf("stall%0d", d), o_stall[d], stl);
            chk($sformatf("starved%0d", d), o_starved[d], m_st[d] == SM);
            chk($sformatf("regs%0d", d),
                {o_valid[d], o_exc[d], o_cause[d], o_pc[d], o_read[d], o_write[d], o_ext[d],
                 o_width[d], o_addr[d], o_wdata[d], o_wb[d]},
                {m_valid[d], m_exc[d], m_pay[d]});
            chk($sformatf("fwd%0d", d), o_fwd[d], m_pay[d].addr);
            e_gi[d] = gi; e_stl[d] = stl;
        end
        @(posedge clk_core);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_valid[d] = 1'b0; m_exc[d] = 1'b0; m_pay[d] = '0; m_ptr[d] = 0; m_st[d] = 0;
            end else begin
                if (csr_kill || !m_valid[d])   m_st[d] = 0;
                else if (mem1_stall)           m_st[d] = m_st[d];
                else if (e_gi[d] >= 0)         m_st[d] = (m_st[d] < SM) ? m_st[d] + 1 : SM;
                else                           m_st[d] = 0;
                if (rrm(d) && e_gi[d] >= 0) m_ptr[d] = (e_gi[d] + 1) % nr(d);
                if (!e_stl[d] || csr_kill) begin
                    m_valid[d] = ex_valid && !ex_stall && !ex_exc && !csr_kill;
                    m_exc[d]   = ex_exc && !csr_kill;
                    m_pay[d]   = '{exc_cause: ex_exc_cause, pc: ex_pc, read: ex_mem_read,
                                   write: ex_mem_write, extend: ex_mem_extend,
                                   width: ex_mem_width, addr: ex_data0, wdata: ex_data1,
                                   wb_reg: ex_wb_reg};
                end
            end
        end
        @(negedge clk_core);
    endtask

    task automatic load(input logic [31:0] ad);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_data0 = ad; ex_data1 = ~ad;
        ex_pc = ad[31:2] + 30'd1; ex_wb_reg = ad[6:2];
    endtask

    initial begin
        logic [31:0] t;
        logic [2:0]  eg;
        reset = 1'b1; ex_valid = 0; ex_stall = 0; ex_exc = 0; ex_mem_read = 0;
        ex_mem_write = 0; ex_mem_extend = 0; csr_kill = 0; mem1_stall = 0;
        ex_exc_cause = '0; ex_pc = '0; ex_data0 = '0; ex_data1 = '0;
        csr_satp = 32'h4AB0_0000; ex_mem_width = 2'd2; ex_wb_reg = '0;
        rq[0] = '0; rq[1] = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) ra[d][i] = AW'(32'h0123_4560 * (d + 1) + i * 32'h111);
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0; m_exc[d] = 0; m_pay[d] = '0; m_ptr[d] = 0; m_st[d] = 0;
        end
        @(negedge clk_core); @(negedge clk_core);
        step();
        reset = 1'b0;

        // 1: idle after reset
        #1 chk("t1_idle", {o_valid[0], if_rr.mem0_dc_read, if_rr.rq_grant, o_starved[0]}, '0);
        step();

        // 2: single load, no requesters
        load(32'h8000_1234);
        step();
        ex_valid = 1'b0;
        t = 32'h8000_1234;
        #1 chk("t2_dc", {if_rr.mem0_dc_read, if_rr.mem0_dc_trans, if_rr.mem0_dc_addr, o_stall[0]},
               {1'b1, 1'b1, t[31:2], 1'b0});
        step();

        // 3 & 6: all requesters held; round-robin rotates, fixed stays on 0
        rq[0] = 3'b111; rq[1] = 3'b011;
        for (int i = 0; i < 6; i++) begin
            eg = 3'b001 << (i % 3);
            #1 chk("t3_rr_grant", if_rr.rq_grant, eg);
            chk("t6_fx_grant", if_fx.rq_grant, 2'b01);
            chk("t6_fx_addr", if_fx.mem0_dc_addr, {3'b000, ra[1][0]});
            step();
        end

        // 4: starvation guard
        rq[0] = 3'b001; rq[1] = 3'b001;
        load(32'h0000_0A00);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < SM; i++) begin
            #1 chk("t4_lost", {o_stall[0], if_rr.rq_grant, if_rr.mem0_dc_trans, o_starved[0]},
                   {1'b1, 3'b001, 1'b0, 1'b0});
            step();
        end
        #1 chk("t4_force", {o_starved[0], if_rr.rq_grant, if_rr.mem0_dc_read,
                            if_rr.mem0_dc_trans, o_stall[0]}, {1'b1, 3'b000, 1'b1, 1'b1, 1'b0});
        step();
        #1 chk("t4_clear", o_starved[0], 1'b0);

        // 5: mem1 back-pressure holds payload, kill clears
        rq[0] = '0; rq[1] = '0;
        load(32'h1000_0040);
        step();
        mem1_stall = 1'b1; load(32'hDEAD_BEE0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t5_hold", {o_stall[0], if_rr.mem0_dc_read, o_valid[0], o_addr[0]},
                   {1'b1, 1'b0, 1'b1, 32'h1000_0040});
            step();
        end
        csr_kill = 1'b1;
        step();
        csr_kill = 1'b0; mem1_stall = 1'b0; ex_valid = 1'b0;
        #1 chk("t5_kill", o_valid[0], 1'b0);
        step();

        // Random phase against the model, including a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            rq[0]         = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            rq[1]         = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 3));
            mem1_stall    = ($urandom_range(0, 3) == 0);
            csr_kill      = ($urandom_range(0, 19) == 0);
            reset         = (i == 200);
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_stall      = ($urandom_range(0, 7) == 0);
            ex_exc        = ($urandom_range(0, 9) == 0);
            ex_exc_cause  = ecause_t'($urandom);
            ex_pc         = 30'($urandom);
            ex_data0      = $urandom;
            ex_data1      = $urandom;
            ex_mem_read   = 1'($urandom);
            ex_mem_write  = 1'($urandom);
            ex_mem_extend = 1'($urandom);
            ex_mem_width  = 2'($urandom);
            ex_wb_reg     = 5'($urandom);
            csr_satp      = $urandom;
            if (i % 16 == 0)
                for (int d = 0; d < 2; d++)
                    for (int k = 0; k < 3; k++) ra[d][k] = AW'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
